// File: rtl/ble_usb_packetizer.sv
// BLE access-address search, byte framing into a whole-frame FIFO, and a
// USB-side byte stream with frame delimiting, backpressure and drop accounting.
module ble_usb_packetizer #(
    parameter int          CHANNEL_W   = 7,
    parameter int          RSSI_W      = 8,
    parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter int          MAX_PAYLOAD = 37,
    parameter int          FIFO_DEPTH  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 serial_i,
    input  logic                 valid_i,
    input  logic [CHANNEL_W-1:0] channel_i,
    input  logic [RSSI_W-1:0]    rssi_i,
    input  logic                 ready_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    output logic                 frame_o,
    output logic                 overflow_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int NEED = MAX_PAYLOAD + 7;

    if (FIFO_DEPTH < NEED) begin : g_depth_check
        $error("FIFO_DEPTH must be at least MAX_PAYLOAD+7");
    end
    if (CHANNEL_W > 8 || RSSI_W > 8) begin : g_width_check
        $error("CHANNEL_W and RSSI_W must not exceed 8");
    end

    typedef enum logic [1:0] {SEARCH, HEADER, PAYLOAD} state_t;

    state_t        state;
    // Older 31 bits of the address window; the current bit completes it.
    logic [30:0]   shift_reg;
    logic [31:0]   window;
    logic [6:0]    byte_acc;
    logic [7:0]    byte_next;
    logic [2:0]    bit_cnt;
    logic          len_phase;
    logic [6:0]    bytes_left;
    logic          chan_pending;
    logic [7:0]    chan_reg;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] start_idx;
    logic [CW-1:0] used_cnt;
    logic [CW-1:0] frames_cnt;
    logic          out_last;

    logic          wr_en;
    logic [8:0]    wr_data;
    logic          detect, detect_ok, detect_drop, byte_done, oversize;
    logic          rollback, commit, avail, load, xfer;

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == AW'(FIFO_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign window      = {serial_i, shift_reg};
    assign byte_next   = {serial_i, byte_acc};
    assign byte_done   = valid_i && (bit_cnt == 3'd7);
    assign detect      = (state == SEARCH) && valid_i && (window == ACCESS_ADDR);
    assign detect_ok   = detect && (int'(used_cnt) <= FIFO_DEPTH - NEED);
    assign detect_drop = detect && !detect_ok;
    assign oversize    = int'(byte_next[5:0]) > MAX_PAYLOAD;
    assign rollback    = (state == HEADER) && byte_done && len_phase && oversize;
    assign commit      = (state == PAYLOAD) && byte_done && (bytes_left == 7'd1);
    assign xfer        = valid_o && ready_i;
    // When the output register holds a frame's last byte, that frame is no longer in memory.
    assign avail       = (valid_o && out_last) ? (frames_cnt > CW'(1)) : (frames_cnt != '0);
    assign load        = avail && (!valid_o || ready_i);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (detect_ok) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, 8'(rssi_i)};
        end else if (chan_pending) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, chan_reg};
        end else if (byte_done && (state == HEADER) && !rollback) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, byte_next};
        end else if (byte_done && (state == PAYLOAD)) begin
            wr_en   = 1'b1;
            wr_data = {commit, byte_next};
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_idx     <= '0;
            start_idx  <= '0;
            used_cnt   <= '0;
            frames_cnt <= '0;
        end else begin
            if (detect_ok) begin
                start_idx <= wr_idx;
            end
            // An oversize frame has written exactly rssi, channel and header.
            if (rollback) begin
                wr_idx <= start_idx;
            end else if (wr_en) begin
                wr_idx <= next_idx(wr_idx);
            end
            used_cnt   <= used_cnt + CW'(wr_en) - CW'(load) - (rollback ? CW'(3) : CW'(0));
            frames_cnt <= frames_cnt + CW'(commit) - CW'(xfer && out_last);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_idx   <= '0;
            data_o   <= '0;
            out_last <= 1'b0;
            valid_o  <= 1'b0;
            frame_o  <= 1'b0;
        end else if (load) begin
            data_o   <= mem[rd_idx][7:0];
            out_last <= mem[rd_idx][8];
            rd_idx   <= next_idx(rd_idx);
            valid_o  <= 1'b1;
            frame_o  <= 1'b1;
        end else if (xfer) begin
            valid_o  <= 1'b0;
            frame_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= SEARCH;
            shift_reg    <= '0;
            byte_acc     <= '0;
            bit_cnt      <= '0;
            len_phase    <= 1'b0;
            bytes_left   <= '0;
            chan_pending <= 1'b0;
            chan_reg     <= '0;
            overflow_o   <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            overflow_o   <= detect_drop;
            chan_pending <= detect_ok;
            if ((detect_drop || rollback) && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            case (state)
                SEARCH: begin
                    if (valid_i) begin
                        shift_reg <= window[31:1];
                        if (detect_ok) begin
                            state     <= HEADER;
                            chan_reg  <= 8'(channel_i);
                            bit_cnt   <= '0;
                            len_phase <= 1'b0;
                        end else if (detect_drop) begin
                            shift_reg <= '0;
                        end
                    end
                end
                HEADER: begin
                    if (valid_i) begin
                        byte_acc <= byte_next[7:1];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            if (!len_phase) begin
                                len_phase <= 1'b1;
                            end else if (oversize) begin
                                state     <= SEARCH;
                                shift_reg <= '0;
                            end else begin
                                state      <= PAYLOAD;
                                bytes_left <= 7'(byte_next[5:0]) + 7'd3;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (valid_i) begin
                        byte_acc <= byte_next[7:1];
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            bytes_left <= bytes_left - 7'd1;
                            if (bytes_left == 7'd1) begin
                                state     <= SEARCH;
                                shift_reg <= '0;
                            end
                        end
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_ble_usb_packetizer.sv
// Scoreboard bench for ble_usb_packetizer: directed packets push expected bytes,
// a negedge monitor pops and compares every transferred byte.
module tb_ble_usb_packetizer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        serial_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [6:0]  channel_i = '0;
    logic [7:0]  rssi_i = '0;
    logic        ready_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    ble_usb_packetizer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .serial_i   (serial_i),
        .valid_i    (valid_i),
        .channel_i  (channel_i),
        .rssi_i     (rssi_i),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_o    (frame_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: one line per transferred byte.
    always @(negedge clk_i) begin
        if (overflow_o) ovf_cnt++;
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %02h, required no output", data_o);
            end else if (ready_i) begin
                $display("[TB] byte %02h (expected %02h) frame=%0b", data_o, exp_q[0], frame_o);
                check("data", 32'(data_o), 32'(exp_q.pop_front()));
                check("frame_during_xfer", 32'(frame_o), 32'd1);
                xfer_cnt++;
            end else begin
                check("stall_data", 32'(data_o), 32'(exp_q[0]));
            end
        end else begin
            check("frame_idle", 32'(frame_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap_max);
        serial_i = b;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        for (int i = 0; i < 8; i++) send_bit(b[i], gap_max);
    endtask

    task automatic send_aa(input int gap_max);
        logic [31:0] aa;
        aa = 32'h8E89BED6;
        for (int i = 0; i < 32; i++) send_bit(aa[i], gap_max);
    endtask

    task automatic send_frame(input logic [7:0] rssi, input logic [6:0] ch, input logic [7:0] hdr,
                              input logic [7:0] len, input int npay, input logic [7:0] pay0,
                              input int gap_max, input bit expect_it);
        if (expect_it) begin
            exp_q.push_back(rssi);
            exp_q.push_back({1'b0, ch});
            exp_q.push_back(hdr);
            exp_q.push_back(len);
            for (int i = 0; i < npay; i++) exp_q.push_back(8'(pay0 + i));
            exp_q.push_back(8'hAA);
            exp_q.push_back(8'hBB);
            exp_q.push_back(8'hCC);
        end
        rssi_i    = rssi;
        channel_i = ch;
        send_aa(gap_max);
        send_byte(hdr, gap_max);
        send_byte(len, gap_max);
        for (int i = 0; i < npay; i++) send_byte(8'(pay0 + i), gap_max);
        send_byte(8'hAA, gap_max);
        send_byte(8'hBB, gap_max);
        send_byte(8'hCC, gap_max);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d bytes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (20) tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_frame", 32'(frame_o), 32'd0);
        check("reset_overflow", 32'(overflow_o), 32'd0);
        check("reset_drop", 32'(drop_cnt_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Single frame
        xfer_cnt = 0;
        send_frame(8'h9C, 7'd37, 8'h40, 8'h06, 6, 8'h01, 0, 1'b1);
        wait_drain("single", 300);
        check("single_xfers", 32'(xfer_cnt), 32'd13);
        check("single_drop", 32'(drop_cnt_o), 32'd0);

        // Oversize length followed by a valid length-2 packet
        xfer_cnt  = 0;
        rssi_i    = 8'h50;
        channel_i = 7'd12;
        send_aa(0);
        send_byte(8'h40, 0);
        send_byte(8'h3F, 0);
        repeat (60) tick();
        check("oversize_drop", 32'(drop_cnt_o), 32'd1);
        check("oversize_no_output", 32'(xfer_cnt), 32'd0);
        send_frame(8'h50, 7'd12, 8'h02, 8'h02, 2, 8'h11, 0, 1'b1);
        wait_drain("after_oversize", 300);
        check("after_oversize_xfers", 32'(xfer_cnt), 32'd9);
        check("after_oversize_drop", 32'(drop_cnt_o), 32'd1);

        // Backpressure: ready low for 5 cycles while the third byte is presented
        xfer_cnt = 0;
        fork
            send_frame(8'h9C, 7'd37, 8'h40, 8'h06, 6, 8'h01, 0, 1'b1);
            begin
                int n = 0;
                while (xfer_cnt < 2 && n < 2000) begin
                    tick();
                    n++;
                end
                check("bp_reached_byte3", 32'(xfer_cnt >= 2), 32'd1);
                ready_i = 1'b0;
                repeat (5) tick();
                check("bp_hold_data", 32'(data_o), 32'h40);
                check("bp_hold_valid", 32'(valid_o), 32'd1);
                ready_i = 1'b1;
            end
        join
        wait_drain("backpressure", 300);
        check("bp_xfers", 32'(xfer_cnt), 32'd13);

        // Overflow: two back-to-back max-length frames with ready low
        do_reset();
        ready_i  = 1'b0;
        xfer_cnt = 0;
        ovf_cnt  = 0;
        send_frame(8'h77, 7'd3, 8'h42, 8'h25, 37, 8'h01, 0, 1'b1);
        send_frame(8'h78, 7'd4, 8'h42, 8'h25, 37, 8'h01, 0, 1'b0);
        repeat (10) tick();
        check("ovf_pulses", 32'(ovf_cnt), 32'd1);
        check("ovf_drop", 32'(drop_cnt_o), 32'd1);
        check("ovf_held_first", 32'(data_o), 32'h77);
        ready_i = 1'b1;
        wait_drain("overflow", 500);
        check("ovf_xfers", 32'(xfer_cnt), 32'd44);

        // Gapped input
        xfer_cnt = 0;
        send_frame(8'h9C, 7'd37, 8'h40, 8'h06, 6, 8'h01, 10, 1'b1);
        wait_drain("gapped", 300);
        check("gapped_xfers", 32'(xfer_cnt), 32'd13);

        // Reset mid-payload while a committed frame is held at the output
        ready_i = 1'b0;
        send_frame(8'h9C, 7'd37, 8'h40, 8'h06, 6, 8'h01, 0, 1'b1);
        send_aa(0);
        send_byte(8'h40, 0);
        send_byte(8'h06, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        repeat (2) tick();
        rst_i = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_frame", 32'(frame_o), 32'd0);
        check("midrst_drop", 32'(drop_cnt_o), 32'd0);
        repeat (2) tick();
        rst_i    = 1'b1;
        ready_i  = 1'b1;
        tick();
        xfer_cnt = 0;
        send_frame(8'h9C, 7'd37, 8'h40, 8'h06, 6, 8'h01, 0, 1'b1);
        wait_drain("after_reset", 300);
        check("after_reset_xfers", 32'(xfer_cnt), 32'd13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
